// File: rtl/reg_mem_bist_pkg.sv
// Shared types and default parameters for the reg_mem BIST initiator.
package reg_mem_bist_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_BITS  = 5;
    localparam int DEF_BASE_VALUE = 10;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ADDR,
        RD_CHK,
        DONE
    } state_t;

    typedef enum logic {
        PH_TRUE,
        PH_INV
    } phase_t;

endpackage

// File: rtl/reg_mem_bist_pattern_gen.sv
// Expected-word generator: (BASE_VALUE + idx) mod 2^DATA_WIDTH, optionally inverted.
module bist_pattern_gen
    import reg_mem_bist_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_BITS  = DEF_ADDR_BITS,
    parameter int BASE_VALUE = DEF_BASE_VALUE
) (
    input  logic [ADDR_BITS:0]    idx,
    input  phase_t                phase,
    output logic [DATA_WIDTH-1:0] pattern
);

    logic [DATA_WIDTH-1:0] sum;

    assign sum     = DATA_WIDTH'(BASE_VALUE) + DATA_WIDTH'(idx);
    assign pattern = (phase == PH_INV) ? ~sum : sum;

endmodule

// File: rtl/reg_mem_bist.sv
// Write/read-back self-test initiator driving a reg_mem.
// Optional second inverted-pattern pass: define REG_MEM_BIST_INV_PASS_EN.
//
// state   | meaning
// IDLE    | waiting for start, outputs at reset values
// WRITE   | writing pattern(idx) to mem_addr=idx, one word per cycle
// RD_ADDR | read address presented, waiting for data to settle
// RD_CHK  | compare mem_rdata with pattern(idx)
// DONE    | result held until next start
module reg_mem_bist
    import reg_mem_bist_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_BITS  = DEF_ADDR_BITS,
    parameter int BASE_VALUE = DEF_BASE_VALUE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_BITS-1:0]  fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wen,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [ADDR_BITS:0] LAST_IDX = (ADDR_BITS+1)'((1 << ADDR_BITS) - 1);
    localparam logic [ADDR_BITS:0] ONE      = (ADDR_BITS+1)'(1);

    state_t                state;
    logic [ADDR_BITS:0]    idx;
    logic [ADDR_BITS:0]    gen_idx;
    logic [DATA_WIDTH-1:0] pattern;
    phase_t                phase;

    // While writing, the generator looks one word ahead so mem_wdata is registered
    always_comb begin
        gen_idx = idx;
        if (state == WRITE) gen_idx = idx + ONE;
    end

    bist_pattern_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (ADDR_BITS),
        .BASE_VALUE (BASE_VALUE)
    ) u_pattern_gen (
        .idx     (gen_idx),
        .phase   (phase),
        .pattern (pattern)
    );

`ifndef REG_MEM_BIST_INV_PASS_EN
    assign phase = PH_TRUE;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wen   <= 1'b0;
`ifdef REG_MEM_BIST_INV_PASS_EN
            phase     <= PH_TRUE;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= WRITE;
                        idx       <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        fail_addr <= '0;
                        fail_data <= '0;
                        mem_addr  <= '0;
                        mem_wdata <= DATA_WIDTH'(BASE_VALUE);
                        mem_wen   <= 1'b1;
`ifdef REG_MEM_BIST_INV_PASS_EN
                        phase     <= PH_TRUE;
`endif
                    end
                end
                WRITE: begin
                    if (idx == LAST_IDX) begin
                        state    <= RD_ADDR;
                        idx      <= '0;
                        mem_addr <= '0;
                        mem_wen  <= 1'b0;
                    end else begin
                        idx       <= gen_idx;
                        mem_addr  <= gen_idx[ADDR_BITS-1:0];
                        mem_wdata <= pattern;
                    end
                end
                RD_ADDR: begin
                    state <= RD_CHK;
                end
                RD_CHK: begin
                    if (mem_rdata != pattern) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= 1'b0;
                        fail_addr <= idx[ADDR_BITS-1:0];
                        fail_data <= mem_rdata;
                    end else if (idx == LAST_IDX) begin
`ifdef REG_MEM_BIST_INV_PASS_EN
                        if (phase == PH_TRUE) begin
                            state     <= WRITE;
                            phase     <= PH_INV;
                            idx       <= '0;
                            mem_addr  <= '0;
                            mem_wdata <= ~DATA_WIDTH'(BASE_VALUE);
                            mem_wen   <= 1'b1;
                        end else
`endif
                        begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end
                    end else begin
                        state    <= RD_ADDR;
                        idx      <= idx + ONE;
                        mem_addr <= idx[ADDR_BITS-1:0] + ADDR_BITS'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_mem_bist.sv
// Directed bench for reg_mem_bist with behavioural reg_mem models and fault injection.
module tb_reg_mem_bist;

`ifdef REG_MEM_BIST_INV_PASS_EN
    localparam int         PASSES   = 2;
    localparam logic [7:0] DATA_XOR = 8'hFF;
`else
    localparam int         PASSES   = 1;
    localparam logic [7:0] DATA_XOR = 8'h00;
`endif
    localparam int LAT_PASS = 96 * PASSES;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, start_w;
    logic       busy_a, done_a, pass_a, wen_a;
    logic       busy_w, done_w, pass_w, wen_w;
    logic [4:0] fail_addr_a, addr_a, fail_addr_w, addr_w;
    logic [7:0] fail_data_a, wdata_a, rdata_a, fail_data_w, wdata_w, rdata_w;

    logic [7:0] mem_a [32];
    logic [7:0] mem_w [32];
    logic       fault_en;
    logic [4:0] fault_addr;
    logic [7:0] fault_and;

    int checks   = 0;
    int failures = 0;
    int cyc;

    always #5 clk = ~clk;

    reg_mem_bist dut (
        .clk(clk), .rst(rst), .start(start_a),
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .fail_addr(fail_addr_a), .fail_data(fail_data_a),
        .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_wen(wen_a),
        .mem_rdata(rdata_a)
    );

    reg_mem_bist #(.BASE_VALUE(250)) dut_wrap (
        .clk(clk), .rst(rst), .start(start_w),
        .busy(busy_w), .done(done_w), .pass(pass_w),
        .fail_addr(fail_addr_w), .fail_data(fail_data_w),
        .mem_addr(addr_w), .mem_wdata(wdata_w), .mem_wen(wen_w),
        .mem_rdata(rdata_w)
    );

    // Combinational-read memory with an AND-mask fault on one address
    always @(posedge clk) if (wen_a) mem_a[addr_a] <= wdata_a;
    always_comb begin
        rdata_a = mem_a[addr_a];
        if (fault_en && addr_a == fault_addr) rdata_a = mem_a[addr_a] & fault_and;
    end

    // Registered-read memory for the wrap-around instance
    always @(posedge clk) begin
        if (wen_w) mem_w[addr_w] <= wdata_w;
        rdata_w <= mem_w[addr_w];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start at edge 0, optionally re-pulse start at edge 'extra', count edges until done
    task automatic run_a(input int extra, output int cycles);
        @(negedge clk) start_a = 1'b1;
        @(posedge clk); #1;
        check("first_wen", wen_a, 1);
        check("first_addr", addr_a, 0);
        check("first_wdata", wdata_a, 10);
        check("start_busy", busy_a, 1);
        check("start_clears_done", done_a, 0);
        cycles = 0;
        while (!done_a && cycles < 800) begin
            @(negedge clk) start_a = (extra != 0 && cycles + 1 == extra);
            @(posedge clk); cycles++; #1;
        end
        start_a = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start_a = 1'b0; start_w = 1'b0;
        fault_en = 1'b0; fault_addr = '0; fault_and = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_pass", pass_a, 0);
        check("rst_wen", wen_a, 0);
        check("rst_addr", addr_a, 0);
        check("rst_wdata", wdata_a, 0);
        check("rst_fail_addr", fail_addr_a, 0);
        check("rst_fail_data", fail_data_a, 0);
        @(negedge clk) rst = 1'b0;

        // Clean run
        run_a(0, cyc);
        check("pass_latency", cyc, LAT_PASS);
        check("pass_done", done_a, 1);
        check("pass_flag", pass_a, 1);
        check("pass_busy", busy_a, 0);
        check("mem0", mem_a[0], 8'd10 ^ DATA_XOR);
        check("mem5", mem_a[5], 8'd15 ^ DATA_XOR);
        check("mem31", mem_a[31], 8'd41 ^ DATA_XOR);
        repeat (3) @(posedge clk);
        #1;
        check("done_hold", done_a, 1);
        check("pass_hold", pass_a, 1);

        // Re-pulsed start mid-test is ignored; start after done restarts
        run_a(40, cyc);
        check("restart_ignored_latency", cyc, LAT_PASS);
        check("restart_pass", pass_a, 1);

        // Whole-word stuck-at-0 at address 7
        fault_en = 1'b1; fault_addr = 5'd7; fault_and = 8'h00;
        run_a(0, cyc);
        check("fault7_latency", cyc, 48);
        check("fault7_pass", pass_a, 0);
        check("fault7_addr", fail_addr_a, 7);
        check("fault7_data", fail_data_a, 8'h00);

        // Bit 0 stuck-at-0 at address 3 (expected 0x0D reads as 0x0C)
        fault_addr = 5'd3; fault_and = 8'hFE;
        run_a(0, cyc);
        check("fault3_latency", cyc, 40);
        check("fault3_pass", pass_a, 0);
        check("fault3_addr", fail_addr_a, 3);
        check("fault3_data", fail_data_a, 8'h0C);
        fault_en = 1'b0;

        // Reset asserted while writing index 12
        @(negedge clk) start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("midrst_addr_before", addr_a, 12);
        check("midrst_wen_before", wen_a, 1);
        rst = 1'b1;
        #1;
        check("midrst_wen", wen_a, 0);
        check("midrst_busy", busy_a, 0);
        check("midrst_done", done_a, 0);
        @(negedge clk) rst = 1'b0;
        run_a(0, cyc);
        check("after_rst_latency", cyc, LAT_PASS);
        check("after_rst_pass", pass_a, 1);

        // BASE_VALUE=250 on a registered-read memory: pattern wraps past 0xFF
        @(negedge clk) start_w = 1'b1;
        @(posedge clk); #1;
        check("wrap_first_wdata", wdata_w, 8'd250);
        cyc = 0;
        while (!done_w && cyc < 800) begin
            @(negedge clk) start_w = 1'b0;
            @(posedge clk); cyc++; #1;
        end
        start_w = 1'b0;
        check("wrap_latency", cyc, LAT_PASS);
        check("wrap_pass", pass_w, 1);
        check("wrap_mem6", mem_w[6], 8'h00 ^ DATA_XOR);
        check("wrap_mem5", mem_w[5], 8'hFF ^ DATA_XOR);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
